imem_loader: RTL and testbench

- Boot-time writer for the byte-organised, little-endian instruction memory.
- Accepts a framed byte stream on a valid/ready interface: 16-bit word count, then payload bytes.
- Assembles the payload into 32-bit words and issues one word write per 4 bytes.
- Holds the CPU in reset until loading finishes. It sits between the host byte link (UART receiver) and the instruction memory write port.

---
 rtl/imem_loader.sv | 194 +++++++++++++++++++
 tb/tb_imem_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader
// Boot-time writer for the byte-organised, little-endian instruction memory.
// Takes a framed byte stream from the host link on a valid/ready handshake.
// A frame is a 16-bit word count (low byte first) followed by the payload.
// The payload is packed four bytes to a word, and each word becomes one
// memory write. The CPU is held in reset until a load finishes cleanly.
//
// Optional feature, enabled by defining IMEM_LOADER_CHECKSUM_EN:
//   The frame carries one trailing byte that must equal the XOR of all
//   payload bytes. A mismatch raises error.
//
// Parameters:
//   MAX_WORDS  capacity in 32-bit words
//   BASE_ADDR  byte address written by the first word
//
// Ports:
//   clk, rst    clock (rising edge) and asynchronous active-high reset
//   start       one-cycle pulse that begins a load (honoured only when idle or done)
//   rx_data     incoming byte
//   rx_valid    rx_data is valid this cycle
//   rx_ready    the loader accepts the byte this cycle
//   mem_we      word write strobe, one cycle per word
//   mem_addr    byte address of the word being written
//   mem_wdata   assembled word, first byte in bits [7:0]
//   busy        load in progress
//   done        load finished
//   error       sticky error: length overflow, or bad checksum when enabled
//   cpu_hold    holds the CPU in reset until a load finishes without error
//   word_count  words written so far in the current load

module imem_loader #(
    parameter int unsigned MAX_WORDS = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold,
    output logic [15:0] word_count
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_CHK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE
    } state_t;
`endif

    localparam logic [15:0] MAX_WORDS_16 = 16'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [15:0] len_q;
    logic [1:0]  byte_idx;
    logic [15:0] len_full;
    logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  xor_q;
`endif

    // The full length is only meaningful during the LEN_HI transfer.
    assign len_full  = {rx_data, len_q[7:0]};
    assign last_word = (word_count + 16'd1) == len_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Receiving states hold rx_ready high, so rx_valid alone marks a transfer.
    always_comb begin
        state_d  = state_q;
        rx_ready = 1'b0;
        mem_we   = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (len_full == 16'd0 || len_full > MAX_WORDS_16) state_d = S_DONE;
                    else                                              state_d = S_DATA;
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (rx_valid && byte_idx == 2'd3) state_d = S_WRITE;
            end
            S_WRITE: begin
                mem_we = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = last_word ? S_CHK : S_DATA;
`else
                state_d = last_word ? S_DONE : S_DATA;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                rx_ready = 1'b1;
                if (rx_valid) state_d = S_DONE;
            end
`endif
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) state_d = S_LEN_LO;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cpu_hold = !(state_q == S_DONE && !error);

    // Datapath: length capture, word assembly, address/count stepping and
    // the sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= 16'd0;
            byte_idx   <= 2'd0;
            mem_wdata  <= 32'd0;
            mem_addr   <= BASE_ADDR;
            word_count <= 16'd0;
            error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q      <= 8'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        byte_idx   <= 2'd0;
                        mem_addr   <= BASE_ADDR;
                        word_count <= 16'd0;
                        error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_q      <= 8'd0;
`endif
                    end
                end
                S_LEN_LO: begin
                    if (rx_valid) len_q[7:0] <= rx_data;
                end
                S_LEN_HI: begin
                    if (rx_valid) begin
                        len_q[15:8] <= rx_data;
                        if (len_full > MAX_WORDS_16) error <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        mem_wdata[{byte_idx, 3'b000} +: 8] <= rx_data;
                        byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_q    <= xor_q ^ rx_data;
`endif
                    end
                end
                S_WRITE: begin
                    word_count <= word_count + 16'd1;
                    mem_addr   <= mem_addr + 32'd4;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (rx_valid && rx_data != xor_q) error <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. Frames are built from random or fixed payloads,
// and the handshake stalls are randomised. Each frame's expected writes and
// final status are worked out from the frame contents with plain arithmetic.
module tb_imem_loader;

    localparam int          MAX_WORDS = 32;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;
    logic [15:0] word_count;

    imem_loader #(.MAX_WORDS(MAX_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatched = 0;
    int cyc = 0;
    int lastAccept = 0;

    logic [31:0] gotAddr[$];
    logic [31:0] gotData[$];
    int          gotCycle[$];
    int          expCycle[$];
    logic [7:0]  payload[$];

    always @(posedge clk) cyc++;

    // Capture every write strobe, sampled away from the active edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            gotAddr.push_back(mem_addr);
            gotData.push_back(mem_wdata);
            gotCycle.push_back(cyc);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one byte and hold it until the loader takes it.
    task automatic sendByte(input logic [7:0] b, input int gapMode, input bit pulseStart,
                            output bit ok);
        ok = 1'b0;
        if (gapMode == 1) begin
            rx_valid = 1'b0;
            @(posedge clk); #1;
        end else if (gapMode == 2) begin
            repeat ($urandom_range(0, 2)) begin
                rx_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        if (pulseStart) start = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = rx_ready;
            @(posedge clk); #1;
            start = 1'b0;
        end
        rx_valid = 1'b0;
        if (ok) lastAccept = cyc;
    endtask

    task automatic pulseStartAlone();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Send a whole frame built from 'payload' and check the result.
    task automatic applyStimulus(input string tag, input int len, input int gapMode,
                                 input int startAtByte, input bit badChk);
        logic [7:0]  frame[$];
        logic [7:0]  chk;
        logic [31:0] expWord;
        bit          ok;
        bit          overflow;
        bit          expErr;
        int          nWords;
        int          waited;

        overflow = (len > MAX_WORDS);
        nWords   = overflow ? 0 : len;
        frame.delete();
        frame.push_back(8'(len));
        frame.push_back(8'(len >> 8));
        chk = 8'h00;
        for (int i = 0; i < 4 * nWords; i++) begin
            frame.push_back(payload[i]);
            chk ^= payload[i];
        end
        expErr = overflow;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (nWords > 0) begin
            frame.push_back(badChk ? (chk ^ 8'h01) : chk);
            if (badChk) expErr = 1'b1;
        end
`endif

        gotAddr.delete(); gotData.delete(); gotCycle.delete(); expCycle.delete();
        pulseStartAlone();

        for (int i = 0; i < frame.size(); i++) begin
            sendByte(frame[i], gapMode, (i == startAtByte), ok);
            if (!ok) begin
                checkOutput({tag, " byte accepted"}, 32'd0, 32'd1);
                break;
            end
            if (i >= 2 && i < 2 + 4 * nWords && ((i - 2) % 4) == 3) expCycle.push_back(lastAccept);
        end

        waited = 0;
        while (done !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);

        checkOutput({tag, " write count"}, 32'(gotAddr.size()), 32'(nWords));
        for (int w = 0; w < nWords && w < gotAddr.size(); w++) begin
            expWord = {payload[4*w+3], payload[4*w+2], payload[4*w+1], payload[4*w]};
            checkOutput($sformatf("%s addr[%0d]", tag, w), gotAddr[w], BASE_ADDR + 32'(4 * w));
            checkOutput($sformatf("%s data[%0d]", tag, w), gotData[w], expWord);
            if (w < expCycle.size())
                checkOutput($sformatf("%s latency[%0d]", tag, w), 32'(gotCycle[w]), 32'(expCycle[w]));
        end
        checkOutput({tag, " done"}, 32'(done), 32'd1);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " rx_ready"}, 32'(rx_ready), 32'd0);
        checkOutput({tag, " error"}, 32'(error), 32'(expErr));
        checkOutput({tag, " cpu_hold"}, 32'(cpu_hold), 32'(expErr));
        checkOutput({tag, " word_count"}, 32'(word_count), 32'(nWords));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " rx_ready"}, 32'(rx_ready), 32'd0);
        checkOutput({tag, " mem_we"}, 32'(mem_we), 32'd0);
        checkOutput({tag, " mem_addr"}, mem_addr, BASE_ADDR);
        checkOutput({tag, " mem_wdata"}, mem_wdata, 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " done"}, 32'(done), 32'd0);
        checkOutput({tag, " error"}, 32'(error), 32'd0);
        checkOutput({tag, " cpu_hold"}, 32'(cpu_hold), 32'd1);
        checkOutput({tag, " word_count"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        int len;

        #12;
        checkResetValues("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Two-word program from the test plan.
        payload = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        applyStimulus("two_words", 2, 0, -1, 1'b0);

        // Length beyond capacity.
        payload.delete();
        applyStimulus("overflow", 33, 0, -1, 1'b0);

        // Single word with rx_valid toggling between bytes.
        payload = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        applyStimulus("stalled", 1, 1, -1, 1'b0);

        // Zero-length frame.
        payload.delete();
        applyStimulus("empty", 0, 0, -1, 1'b0);

        // Exactly full capacity.
        payload.delete();
        for (int i = 0; i < 4 * MAX_WORDS; i++) payload.push_back(8'($urandom));
        applyStimulus("full", MAX_WORDS, 2, -1, 1'b0);

        // Reset in the middle of a one-word frame.
        gotAddr.delete();
        pulseStartAlone();
        sendByte(8'h01, 0, 1'b0, ok);
        sendByte(8'h00, 0, 1'b0, ok);
        sendByte(8'h55, 0, 1'b0, ok);
        sendByte(8'h66, 0, 1'b0, ok);
        #3 rst = 1'b1;
        #1 checkResetValues("midload_reset");
        @(posedge clk); #2 rst = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("midload no write", 32'(gotAddr.size()), 32'd0);
        payload = '{8'h01, 8'h02, 8'h03, 8'h04};
        applyStimulus("after_reset", 1, 0, -1, 1'b0);

        // Start pulsed while payload is streaming: must be ignored.
        payload = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        applyStimulus("start_in_data", 2, 0, 4, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        payload = '{8'h11, 8'h22, 8'h33, 8'h44};
        applyStimulus("chk_good", 1, 0, -1, 1'b0);
        applyStimulus("chk_bad", 1, 0, -1, 1'b1);
`endif

        // Random frames, each started from DONE.
        for (int f = 0; f < 14; f++) begin
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(MAX_WORDS + 1, MAX_WORDS + 300)
                                              : $urandom_range(0, MAX_WORDS);
            payload.delete();
            for (int i = 0; i < 4 * MAX_WORDS; i++) payload.push_back(8'($urandom));
            applyStimulus($sformatf("rand%0d", f), len, $urandom_range(0, 2),
                          ($urandom_range(0, 3) == 0) ? 3 + $urandom_range(0, 3) : -1,
                          1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
